// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned shift-and-add multiplier.
// Computes multiplier * multiplicand in N iterations (one bit per cycle).
// Optional feature macro: MULT_ADDEND_EN -- when defined, the accumulator
// is preloaded with addend so the result is multiplier*multiplicand + addend.
// The port list is identical in both builds.
//
// Handshake: start is sampled only in IDLE; operands are latched on that
// edge. busy is high while iterating (RUN). done is a one-cycle pulse (DONE)
// during which product is valid; product is then held until the next
// accepted operation completes, or until rst clears it.
module shift_add_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  input  logic [N-1:0]   addend,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;

  // P = {carry, acc[N-1:0], mpl[N-1:0]}
  logic [2*N:0]   p;
  logic [N-1:0]   mb;
  logic [CW-1:0]  cnt;

  logic [N-1:0]   c0;
  logic [N:0]     sum;
  logic [2*N:0]   p_shift;
  logic           last_iter;

  // Accumulator preload value chosen at build time.
`ifdef MULT_ADDEND_EN
  assign c0 = addend;
`else
  // addend is present but has no effect on the result in this build.
  assign c0 = addend & {N{1'b0}};
`endif

  // The carry bit is zero after every shift; folding it into the add keeps
  // the full N+1-bit partial sum explicit.
  assign sum       = {p[2*N], p[2*N-1:N]} + {1'b0, mb};
  assign last_iter = (cnt == LAST_CNT);

  // One iteration: conditional add of MB into acc, then logical right shift
  // of the whole {carry, acc, mpl} register so the carry enters acc's MSB.
  always_comb begin
    p_shift = {1'b0, p[2*N:1]};
    if (p[0]) begin
      p_shift = {1'b0, sum, p[N-1:1]};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, iteration and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      p       <= '0;
      mb      <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mb  <= multiplicand;
            p   <= {1'b0, c0, multiplier};
            cnt <= '0;
          end
        end
        RUN: begin
          p   <= p_shift;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            product <= p_shift[2*N-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential unsigned shift-and-add multiplier. It is the inverse-direction companion of the restoring division datapath.
- Takes a multiplicand and a multiplier and produces a 2N-bit product after N iteration cycles.
- With the optional addend enabled, it computes quotient*divisor + remainder. This lets the bench and the system reconstruct and cross-check a dividend from the divider's outputs.
- Self-contained: the FSM, the accumulator/shift register and the adder are all inside the block.

Parameters:
- N, 8, operand width in bits. The product is 2N bits. Legal N >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a multiply; sampled only in IDLE.
- multiplicand  input  N  operand B, latched when start is accepted.
- multiplier  input  N  operand A, latched when start is accepted.
- addend  input  N  operand C, latched when start is accepted; ignored unless MULT_ADDEND_EN is defined.
- busy  output  1  high while an operation is in progress (state RUN).
- done  output  1  one-cycle pulse marking the product valid.
- product  output  2N  result A*B (or A*B+C); held until the next accepted start.

Behaviour:
- Reset, rst=1 at a rising edge:
  - state = IDLE, busy = 0, done = 0, product = 0.
  - Internal accumulator, multiplicand register and iteration counter are cleared.
  - rst has priority over every other input, including mid-operation. Any in-flight result is discarded, with no done pulse.
- Internal storage:
  - Shift register P of 2N+1 bits: {carry, acc[N-1:0], mpl[N-1:0]}.
  - Multiplicand register MB of N bits.
  - Counter cnt of clog2(N+1) bits.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: MB <= multiplicand; P <= {1'b0, C0, multiplier}; cnt <= 0; state <= RUN.
  - C0 = addend if MULT_ADDEND_EN is defined, else 0.
  - start=0: remain in IDLE; product holds its last value.
- RUN, one iteration per edge, at edges k+1 through k+N:
  - If P[0]=1: {carry, acc} = acc + MB (N+1-bit sum). Otherwise {carry, acc} = {0, acc}.
  - Then P <= {0, carry, acc, mpl[N-1:1]}, a logical right shift by 1. cnt <= cnt+1.
  - At the edge where cnt reaches N-1, the last iteration completes. In that same edge: state <= DONE, product <= P[2N-1:0] after the update, done <= 1.
- DONE:
  - Lasts exactly one cycle; next edge goes to IDLE with done <= 0.
- Handshake and latency:
  - start at edge k gives done=1 in the cycle following edge k+N. Latency is N+1 edges: 9 for N=8.
  - busy=1 exactly while state=RUN, i.e. the N cycles after edge k.
  - start while RUN or DONE is ignored; operands are not re-latched.
  - Back-to-back: start may be asserted in the cycle after DONE (IDLE). Minimum issue interval is N+2 cycles.
- Operand changes after acceptance have no effect.
- Arithmetic and width:
  - Unsigned only.
  - Result fits 2N bits with no overflow: max (2^N-1)^2 + (2^N-1) < 2^(2N).
  - The carry bit must be carried into the shift; dropping it corrupts products with A,B near 2^N-1.
- product is registered and glitch-free. It changes only at the DONE transition edge or on rst.

Optional Feature:
- MULT_ADDEND_EN.
- Defined: acc is preloaded with addend at start, so product = multiplier*multiplicand + addend. Same latency.
- Not defined: acc is preloaded with 0, product = multiplier*multiplicand, and the addend port is present but unused. Port list is identical in both builds.

Test Plan:
- Reset, then start with multiplier=13, multiplicand=11 -> busy high 8 cycles; done pulses 9 edges after start; product=143 (0x008F); product holds 143 while idle.
- multiplier=255, multiplicand=255 -> product=65025 (0xFE01); checks carry handling. Then 0 x 200 -> product=0, done still pulses.
- MULT_ADDEND_EN defined: multiplier=5, multiplicand=7, addend=3 -> product=38, reconstructing 38/7 = q5 r3. Also 255*255+255 -> 65280 (0xFF00).
- start held high continuously, with operands changed to 2,2 during RUN, while the first op is 6*9 -> first product=54. A new op (4) is accepted only in IDLE after DONE; exactly one done per accepted op.
- rst asserted 4 cycles into a 100*100 operation -> next edge busy=0, done=0, product=0, with no done pulse. A subsequent 3*4 -> 12.
- Sweep all 65536 operand pairs for N=8 against a reference model -> every product exact, done exactly once per start.
